// File: rtl/dcap_pkg.sv
// ============================================================================
// Module : dcap_pkg
// Brief  : Shared types for the dcap_bank capture register bank.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dcap_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'd0,
        MODE_LOAD  = 2'd1,
        MODE_SHIFT = 2'd2,
        MODE_CLEAR = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_VALID = 2'd2
    } snap_state_t;

endpackage : dcap_pkg

`default_nettype wire

// File: rtl/dcap_channel.sv
// ============================================================================
// Module : dcap_channel
// Brief  : One WIDTH-bit capture channel with enable and four update modes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dcap_channel
    import dcap_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] shift_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (en) begin
            case (mode)
                MODE_LOAD:  r_q <= d;
                MODE_SHIFT: r_q <= shift_in;
                MODE_CLEAR: r_q <= '0;
                default:    r_q <= r_q;
            endcase
        end
    end

    assign q = r_q;

endmodule : dcap_channel

`default_nettype wire

// File: rtl/dcap_bank.sv
// ============================================================================
// Module : dcap_bank
// Brief  : NCH-channel capture bank with handshaked snapshot unit.
//          Optional per-channel parity output under DCAP_PARITY_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dcap_bank
    import dcap_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic [NCH-1:0]       en,
    input  logic [NCH*WIDTH-1:0] d,
    output logic [NCH*WIDTH-1:0] q,
    input  logic                 snap_req,
    input  logic                 trig,
    input  logic                 snap_ack,
    output logic [NCH*WIDTH-1:0] snap,
`ifdef DCAP_PARITY_EN
    output logic [NCH-1:0]       par,
`endif
    output logic                 snap_valid,
    output logic                 busy
);

    mode_t                w_mode;
    logic [NCH*WIDTH-1:0] w_q;

    assign w_mode = mode_t'(mode);

    // Each channel shifts from its lower neighbour's pre-edge value;
    // channel 0 takes its own d slice.
    generate
        for (genvar i = 0; i < NCH; i++) begin : g_chan
            logic [WIDTH-1:0] w_shift_in;
            if (i == 0) begin : g_head
                assign w_shift_in = d[0 +: WIDTH];
            end else begin : g_link
                assign w_shift_in = w_q[(i-1)*WIDTH +: WIDTH];
            end

            dcap_channel #(
                .WIDTH (WIDTH)
            ) u_chan (
                .clk      (clk),
                .rst      (rst),
                .en       (en[i]),
                .mode     (w_mode),
                .d        (d[i*WIDTH +: WIDTH]),
                .shift_in (w_shift_in),
                .q        (w_q[i*WIDTH +: WIDTH])
            );
        end
    endgenerate

    assign q = w_q;

    snap_state_t          r_state;
    snap_state_t          w_state_nxt;
    logic                 w_capture;
    logic [NCH*WIDTH-1:0] r_snap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (snap_req) w_state_nxt = ST_ARMED;
            ST_ARMED: if (trig)     w_state_nxt = ST_VALID;
            ST_VALID: if (snap_ack) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != ST_IDLE);
        snap_valid = (r_state == ST_VALID);
        w_capture  = (r_state == ST_ARMED) && trig;
    end

    // Snapshot keeps its value across the ack until the next capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap <= '0;
        end else if (w_capture) begin
            r_snap <= w_q;
        end
    end

    assign snap = r_snap;

`ifdef DCAP_PARITY_EN
    logic [NCH-1:0] w_par;

    generate
        for (genvar p = 0; p < NCH; p++) begin : g_par
            assign w_par[p] = ^w_q[p*WIDTH +: WIDTH];
        end
    endgenerate

    assign par = rst ? '0 : w_par;
`endif

endmodule : dcap_bank

`default_nettype wire

// File: tb/tb_dcap_bank.sv
// ============================================================================
// Module : tb_dcap_bank
// Brief  : Directed self-checking bench for dcap_bank (WIDTH=8, NCH=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dcap_bank;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [3:0]  en;
    logic [31:0] d;
    logic [31:0] q;
    logic        snap_req;
    logic        trig;
    logic        snap_ack;
    logic [31:0] snap;
    logic        snap_valid;
    logic        busy;
`ifdef DCAP_PARITY_EN
    logic [3:0]  par;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    dcap_bank #(
        .WIDTH (WIDTH),
        .NCH   (NCH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .en         (en),
        .d          (d),
        .q          (q),
        .snap_req   (snap_req),
        .trig       (trig),
        .snap_ack   (snap_ack),
        .snap       (snap),
`ifdef DCAP_PARITY_EN
        .par        (par),
`endif
        .snap_valid (snap_valid),
        .busy       (busy)
    );

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] val);
        mode = 2'd1; en = 4'hF; d = val;
        step();
        mode = 2'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 2'd1; en = 4'hF; d = 32'hDEADBEEF;
        snap_req = 1'b1; trig = 1'b1; snap_ack = 1'b0;
        step();
        step();
        vectors++; if (q !== 32'h0) begin errors++; $display("FAIL reset_q got=%h exp=%h", q, 32'h0); end
        vectors++; if (snap !== 32'h0) begin errors++; $display("FAIL reset_snap got=%h exp=%h", snap, 32'h0); end
        vectors++; if (snap_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", snap_valid); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0; mode = 2'd0; snap_req = 1'b0; trig = 1'b0;
    endtask

    task automatic test_load();
        load(32'h44332211);
        vectors++; if (q !== 32'h44332211) begin errors++; $display("FAIL load_q got=%h exp=%h", q, 32'h44332211); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++; if (q !== 32'h0) begin errors++; $display("FAIL rst_after_load_q got=%h exp=%h", q, 32'h0); end
        vectors++; if (snap_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_after_load_flags got=%b%b exp=00", snap_valid, busy); end
    endtask

    task automatic test_shift();
        load(32'h44332211);
        mode = 2'd2; en = 4'hF; d = 32'h000000AA;
        step();
        vectors++; if (q !== 32'h332211AA) begin errors++; $display("FAIL shift_all got=%h exp=%h", q, 32'h332211AA); end
        en = 4'b1011;
        step();
        vectors++; if (q !== 32'h2222AAAA) begin errors++; $display("FAIL shift_gated got=%h exp=%h", q, 32'h2222AAAA); end
        mode = 2'd0;
    endtask

    task automatic test_clear_hold();
        load(32'h44332211);
        mode = 2'd3; en = 4'b0101;
        step();
        vectors++; if (q !== 32'h44002200) begin errors++; $display("FAIL clear_gated got=%h exp=%h", q, 32'h44002200); end
        mode = 2'd0; en = 4'hF; d = 32'h12121212;
        step();
        vectors++; if (q !== 32'h44002200) begin errors++; $display("FAIL hold got=%h exp=%h", q, 32'h44002200); end
    endtask

    task automatic test_snapshot();
        load(32'h12345678);
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        vectors++; if (busy !== 1'b1 || snap_valid !== 1'b0) begin errors++; $display("FAIL armed_flags got=%b%b exp=10", busy, snap_valid); end
        trig = 1'b1; mode = 2'd1; en = 4'hF; d = 32'hFFFFFFFF;
        step();
        trig = 1'b0; mode = 2'd0;
        vectors++; if (snap !== 32'h12345678) begin errors++; $display("FAIL capture_snap got=%h exp=%h", snap, 32'h12345678); end
        vectors++; if (snap_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL capture_flags got=%b%b exp=11", snap_valid, busy); end
        vectors++; if (q !== 32'hFFFFFFFF) begin errors++; $display("FAIL capture_q got=%h exp=%h", q, 32'hFFFFFFFF); end
        // trig and snap_req in VALID must be ignored
        trig = 1'b1; snap_req = 1'b1; mode = 2'd1; d = 32'h00000000;
        step();
        trig = 1'b0; snap_req = 1'b0; mode = 2'd0;
        vectors++; if (snap !== 32'h12345678 || snap_valid !== 1'b1) begin errors++; $display("FAIL valid_retrig got=%h/%b exp=%h/1", snap, snap_valid, 32'h12345678); end
        snap_ack = 1'b1;
        step();
        snap_ack = 1'b0;
        vectors++; if (snap_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ack_flags got=%b%b exp=00", snap_valid, busy); end
        vectors++; if (snap !== 32'h12345678) begin errors++; $display("FAIL ack_snap_kept got=%h exp=%h", snap, 32'h12345678); end
    endtask

    task automatic test_req_trig_same();
        load(32'hCAFEBABE);
        trig = 1'b1; snap_ack = 1'b1;
        step();
        snap_ack = 1'b0;
        vectors++; if (busy !== 1'b0 || snap_valid !== 1'b0) begin errors++; $display("FAIL idle_ignore got=%b%b exp=00", busy, snap_valid); end
        snap_req = 1'b1;
        step();
        snap_req = 1'b0; trig = 1'b0;
        vectors++; if (busy !== 1'b1 || snap_valid !== 1'b0) begin errors++; $display("FAIL req_trig_same got=%b%b exp=10", busy, snap_valid); end
        step();
        vectors++; if (busy !== 1'b1 || snap_valid !== 1'b0) begin errors++; $display("FAIL armed_wait got=%b%b exp=10", busy, snap_valid); end
        trig = 1'b1;
        step();
        trig = 1'b0;
        vectors++; if (snap !== 32'hCAFEBABE || snap_valid !== 1'b1) begin errors++; $display("FAIL late_trig got=%h/%b exp=%h/1", snap, snap_valid, 32'hCAFEBABE); end
        snap_ack = 1'b1;
        step();
        snap_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++; if (busy !== 1'b0 || snap !== 32'h0) begin errors++; $display("FAIL rst_armed got=%b/%h exp=0/%h", busy, snap, 32'h0); end
        load(32'h5A5A5A5A);
        snap_req = 1'b1;
        step();
        snap_req = 1'b0; trig = 1'b1;
        step();
        trig = 1'b0;
        vectors++; if (snap !== 32'h5A5A5A5A || snap_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid got=%h/%b exp=%h/1", snap, snap_valid, 32'h5A5A5A5A); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++; if (busy !== 1'b0 || snap_valid !== 1'b0 || snap !== 32'h0) begin errors++; $display("FAIL rst_valid got=%b%b/%h exp=00/%h", busy, snap_valid, snap, 32'h0); end
    endtask

`ifdef DCAP_PARITY_EN
    task automatic test_parity();
        load(32'h00000301);
        vectors++; if (par !== 4'b0001) begin errors++; $display("FAIL parity got=%b exp=0001", par); end
        load(32'h80FF0703);
        vectors++; if (par !== 4'b1010) begin errors++; $display("FAIL parity2 got=%b exp=1010", par); end
    endtask
`endif

    initial begin
        rst = 1'b1; mode = 2'd0; en = 4'h0; d = 32'h0;
        snap_req = 1'b0; trig = 1'b0; snap_ack = 1'b0;
        test_reset();
        test_load();
        test_shift();
        test_clear_hold();
        test_snapshot();
        test_req_trig_same();
        test_reset_mid();
`ifdef DCAP_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_dcap_bank

`default_nettype wire
